// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshake and a private accumulator.
// S1 registers the operand bundle; S2 computes and registers the result and flags.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_ACC = 3'd7
  } op_e;

  logic [2:1]       vld_pipe_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, c_q;
  op_e              op_q;
  logic             carry_q, zero_q, neg_q, ovf_q;
  logic             en;

  logic [WIDTH-1:0] res_d;
  logic [WIDTH:0]   ext_d;
  logic             carry_d, ovf_d;

  // Single advance enable: the whole pipe (and acc) freezes on output backpressure.
  assign en        = !vld_pipe_q[2] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[2];
  assign c         = c_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  always_comb begin
    res_d   = '0;
    ext_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        ext_d   = {1'b0, a_q} + {1'b0, b_q};
        res_d   = ext_d[M:0];
        carry_d = ext_d[WIDTH];
        ovf_d   = (a_q[M] == b_q[M]) && (res_d[M] != a_q[M]);
      end
      OP_SUB: begin
        // Borrow falls out of the extended subtraction's top bit.
        ext_d   = {1'b0, a_q} - {1'b0, b_q};
        res_d   = ext_d[M:0];
        carry_d = ext_d[WIDTH];
        ovf_d   = (a_q[M] != b_q[M]) && (res_d[M] != a_q[M]);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SHL: res_d = a_q << b_q[SHW-1:0];
      OP_SHR: res_d = a_q >> b_q[SHW-1:0];
      OP_ACC: begin
        ext_d   = {1'b0, acc_q} + {1'b0, a_q};
        res_d   = ext_d[M:0];
        carry_d = ext_d[WIDTH];
        ovf_d   = (acc_q[M] == a_q[M]) && (res_d[M] != acc_q[M]);
      end
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      acc_q      <= '0;
      c_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[1], in_valid};
      if (in_valid) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_e'(op);
      end
      if (vld_pipe_q[1]) begin
        c_q     <= res_d;
        carry_q <= carry_d;
        zero_q  <= (res_d == '0);
        neg_q   <= res_d[M];
        ovf_q   <= ovf_d;
        // acc commits in the same edge the ACC result lands, so a following ACC in S1 sees it.
        if (op_q == OP_ACC) acc_q <= res_d;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: streamed vector table plus stall and reset sequences.
module tb_alu_pipe;
  logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, c;
  logic [2:0] op;
  logic       carry, zero, neg, ovf;
  int         n_chk, n_pass;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] c;
    logic       cy, z, n, o;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  initial begin
    logic [7:0] acc_a [3];
    logic [11:0] acc_e [3];
    int n_sent, n_recv, cyc;
    logic sent_pending, held;
    logic [7:0] held_c;

    n_chk = 0; n_pass = 0;
    tv[0]  = '{8'h07, 8'h03, 3'd0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{8'h03, 8'h07, 3'd1, 8'hFC, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[6]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{8'h01, 8'h0B, 3'd5, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{8'h80, 8'h07, 3'd6, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{8'hA5, 8'h08, 3'd5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{8'h05, 8'h05, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[12] = '{8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    // {c, carry, zero, neg, ovf}
    acc_a[0] = 8'd5;   acc_e[0] = {8'd5,   4'b0000};
    acc_a[1] = 8'd250; acc_e[1] = {8'd255, 4'b0010};
    acc_a[2] = 8'd1;   acc_e[2] = {8'd0,   4'b1100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_c_flags", {c, carry, zero, neg, ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Streamed table: vector i driven in cycle i, result visible in cycle i+2.
    for (int i = 0; i < NV + 3; i++) begin
      @(negedge clk);
      if (i >= 2 && i - 2 < NV) begin
        chk($sformatf("tv%0d_valid", i - 2), out_valid, 1);
        chk($sformatf("tv%0d_res", i - 2), {c, carry, zero, neg, ovf},
            {tv[i-2].c, tv[i-2].cy, tv[i-2].z, tv[i-2].n, tv[i-2].o});
      end else begin
        chk($sformatf("bubble%0d_valid", i), out_valid, 0);
      end
      if (i < NV) begin
        in_valid = 1'b1; a = tv[i].a; b = tv[i].b; op = tv[i].op;
      end else begin
        in_valid = 1'b0;
      end
    end

    // ACC chain under toggling out_ready.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    n_sent = 0; n_recv = 0; sent_pending = 1'b0; held = 1'b0; held_c = '0;
    for (cyc = 0; cyc < 40 && n_recv < 3; cyc++) begin
      @(negedge clk);
      if (sent_pending) n_sent++;
      out_ready = cyc[0];
      in_valid  = (n_sent < 3);
      a         = (n_sent < 3) ? acc_a[n_sent] : 8'h00;
      b         = 8'h00;
      op        = 3'd7;
      #1;
      if (held) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_c", c, held_c);
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        held = 1'b1; held_c = c;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("acc%0d_res", n_recv), {c, carry, zero, neg, ovf}, acc_e[n_recv]);
        n_recv++;
      end
      sent_pending = in_valid && in_ready;
    end
    chk("acc_results_seen", n_recv, 3);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with two ACC bundles in flight.
    in_valid = 1'b1; op = 3'd7; a = 8'd9;
    @(negedge clk); a = 8'd3;
    @(negedge clk); in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    chk("inflight_c", c, 8'd9);
    rst = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c_flags", {c, carry, zero, neg, ovf}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; op = 3'd7; a = 8'd4;
    @(negedge clk); in_valid = 1'b0;
    chk("postrst_s1_only", out_valid, 0);
    @(negedge clk);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_acc4", {c, carry, zero, neg, ovf}, {8'd4, 4'b0000});
    @(negedge clk);
    chk("postrst_drain", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a power of two, >= 4.
REQ-002 Localparam SHW = log2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand bundle (a, b, op) valid.
REQ-006 in_ready  output  1  block accepts bundle this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned/two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select (REQ-014).
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 c  output  WIDTH  result.
REQ-013 carry, zero, neg, ovf  output  1 each  result flags.

Function
REQ-014 op codes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SHL a<<b[SHW-1:0]; 6 SHR logical a>>b[SHW-1:0]; 7 ACC acc+a.
REQ-015 Two-stage pipeline: S1 registers a, b, op; S2 computes and registers c and flags; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-016 Global advance enable en = !out_valid || out_ready; in_ready = en (combinational); when en=0 both stages and acc hold.
REQ-017 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 When en=1, S1 valid <= in_valid, S2 valid (out_valid) <= S1 valid; bubbles propagate, no duplicate or dropped results.
REQ-019 c, flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Arithmetic modulo 2^WIDTH; results truncated to WIDTH bits.
REQ-021 carry: ADD/ACC = carry-out of bit WIDTH-1; SUB = borrow (1 iff a < b unsigned); 0 for ops 2-6.
REQ-022 ovf: signed two's-complement overflow for ADD, SUB, ACC; 0 for ops 2-6.
REQ-023 zero = (c == 0); neg = c[WIDTH-1]; valid for all ops.
REQ-024 Shift amount uses only b[SHW-1:0]; upper bits of b ignored; shift by 0 returns a.
REQ-025 Internal accumulator acc (WIDTH bits): updated to result only when an ACC op moves S1->S2; non-ACC ops leave acc unchanged.
REQ-026 Back-to-back ACC ops chain: each uses acc value including all earlier ACC results, independent of stalls.
REQ-027 acc wraps modulo 2^WIDTH; carry/ovf reported per REQ-021/022.

Reset
REQ-028 rst=1 asynchronously clears S1/S2 valid, out_valid=0, c=0, carry=zero=neg=ovf=0, acc=0.
REQ-029 During rst, in_ready = 1 (en true since out_valid=0); no input accepted while rst asserted.
REQ-030 Reset mid-operation discards all in-flight bundles; first result after release comes from first input accepted after release.

Verification
REQ-031 WIDTH=8, out_ready=1: a=7,b=3,op=0 at cycle N -> c=10, carry=0, zero=0, out_valid at N+2 for one cycle.
REQ-032 Stream op=1 a=3,b=7; op=2 a=0xF0,b=0x3C; op=3 same; op=4 same -> c=0xFC carry=1 neg=1; 0x30; 0xFC; 0xCC, consecutive cycles.
REQ-033 a=0x7F,b=0x01,op=0 -> c=0x80 ovf=1 neg=1 carry=0; a=0xFF,b=0x01,op=0 -> c=0x00 carry=1 zero=1 ovf=0.
REQ-034 op=5 a=0x01,b=0x0B -> c=0x08 (b[2:0]=3); op=6 a=0x80,b=0x07 -> c=0x01.
REQ-035 After reset: ACC a=5, ACC a=250, ACC a=1 with out_ready toggling 1/0 -> c=5, 255, 0 (carry=1, zero=1) in order, each held stable while out_ready=0, in_ready=0 during stall.
REQ-036 Assert rst with two bundles in flight -> out_valid=0 immediately, c=0, acc=0; next ACC a=4 after release -> c=4.
